// File: rtl/fir_seq_pkg.sv
// -----------------------------------------------------------------------------
// fir_seq_pkg
// Shared definitions for the FIR sequencer slice: the controller state
// encoding and the default filter geometry (tap count and datapath latency).
// -----------------------------------------------------------------------------
package fir_seq_pkg;

  // Default number of filter taps and datapath latency (rd_addr -> accumulator).
  localparam int DEFAULT_N_TAPS = 8;
  localparam int DEFAULT_PIPE   = 1;

  // Controller states. FLUSH is the reset state and zero-fills the sample
  // buffer; IDLE waits for a sample; MAC walks the taps; DRAIN lets the
  // datapath pipeline empty; DUMP latches the sum; OUT presents the result.
  typedef enum logic [2:0] {
    FLUSH,
    IDLE,
    MAC,
    DRAIN,
    DUMP,
    OUT
  } fir_state_e;

endpackage

// File: rtl/fir_seq_ptr.sv
// -----------------------------------------------------------------------------
// fir_seq_ptr
// Modular up-counter used for the sample-buffer write pointer, the tap index
// and the flush address. Counts 0..N-1 and wraps, so non-power-of-two tap
// counts are handled correctly.
//
// Ports:
//   CLK         clock
//   RST         synchronous active-high reset, clears the count to 0
//   en_i        advance the count by one (modulo N)
//   load_i      load load_val_i (takes priority over en_i)
//   load_val_i  value to load
//   cnt_o       current count
// -----------------------------------------------------------------------------
module fir_seq_ptr #(
  parameter int N  = 8,
  parameter int AW = $clog2(N)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          en_i,
  input  logic          load_i,
  input  logic [AW-1:0] load_val_i,
  output logic [AW-1:0] cnt_o
);

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cnt_d;

  // Next count: load wins over increment; increment wraps at N-1 rather than
  // at the natural binary boundary.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fir_sequencer.sv
// -----------------------------------------------------------------------------
// fir_sequencer
// Control sequencer for a time-multiplexed FIR filter. After reset it
// zero-fills the circular sample buffer, then for each accepted sample it
// writes the sample, walks all taps (newest sample with coefficient 0,
// going back in time), waits for the datapath pipeline to drain, strobes the
// accumulator to latch its result and presents it with a valid/ready
// handshake.
//
// Optional feature: define FIR_SEQ_CNT_EN to add the 16-bit out_count port,
// a wrapping count of completed output handshakes.
//
// Ports:
//   CLK        clock
//   RST        synchronous active-high reset
//   in_valid   new input sample offered
//   in_ready   sequencer accepts sample (IDLE only)
//   out_ready  downstream accepts filter result
//   out_valid  accumulator holds a valid result
//   wr_en      sample-buffer write strobe
//   wr_zero    write data forced to zero (flush)
//   wr_addr    sample-buffer write address
//   rd_addr    sample-buffer read address
//   coef_addr  coefficient ROM address
//   mac_en     multiply-accumulate term valid this cycle
//   out_sel    accumulator latch-result / clear-sum strobe
//   busy       high in every state except IDLE
//   out_count  (FIR_SEQ_CNT_EN only) completed output count
// -----------------------------------------------------------------------------
module fir_sequencer
  import fir_seq_pkg::*;
#(
  parameter int N_TAPS = DEFAULT_N_TAPS,
  parameter int AW     = $clog2(N_TAPS),
  parameter int PIPE   = DEFAULT_PIPE
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          out_valid,
  output logic          wr_en,
  output logic          wr_zero,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] coef_addr,
  output logic          mac_en,
  output logic          out_sel,
  output logic          busy
`ifdef FIR_SEQ_CNT_EN
  ,
  output logic [15:0]   out_count
`endif
);

  localparam logic [AW-1:0] LAST_TAP   = AW'(N_TAPS - 1);
  localparam logic [2:0]    DRAIN_LAST = (PIPE > 0) ? 3'(PIPE - 1) : 3'd0;

  fir_state_e    state_q;
  logic [AW-1:0] newest_q;
  logic [2:0]    drain_q;

  logic [AW-1:0] wPtr;
  logic [AW-1:0] kIdx;
  logic [AW-1:0] flushIdx;
  logic [AW-1:0] rdCalc;
  logic          handshake;

  assign handshake = (state_q == IDLE) && in_valid;

  // Write pointer: advances once per accepted sample.
  fir_seq_ptr #(.N(N_TAPS), .AW(AW)) u_wptr (
    .CLK        (CLK),
    .RST        (RST),
    .en_i       (handshake),
    .load_i     (1'b0),
    .load_val_i ('0),
    .cnt_o      (wPtr)
  );

  // Tap index: restarted on every accepted sample, stepped through MAC.
  // It wraps back to 0 on the last MAC cycle, so it is already clean for the
  // next sample as well.
  fir_seq_ptr #(.N(N_TAPS), .AW(AW)) u_kidx (
    .CLK        (CLK),
    .RST        (RST),
    .en_i       (state_q == MAC),
    .load_i     (handshake),
    .load_val_i ('0),
    .cnt_o      (kIdx)
  );

  // Flush address: steps through the whole buffer while in FLUSH and wraps
  // to 0 on the cycle FLUSH ends.
  fir_seq_ptr #(.N(N_TAPS), .AW(AW)) u_flush (
    .CLK        (CLK),
    .RST        (RST),
    .en_i       (state_q == FLUSH),
    .load_i     (1'b0),
    .load_val_i ('0),
    .cnt_o      (flushIdx)
  );

  // Read address walks backwards from the newest sample. The subtraction is
  // done with one extra bit and corrected by N_TAPS so the wrap is right for
  // tap counts that are not a power of two.
  always_comb begin
    if (newest_q >= kIdx) begin
      rdCalc = newest_q - kIdx;
    end else begin
      rdCalc = AW'(({1'b0, newest_q} + (AW+1)'(N_TAPS)) - {1'b0, kIdx});
    end
  end

  // Controller state machine.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= FLUSH;
      newest_q <= '0;
      drain_q  <= '0;
    end else begin
      case (state_q)
        FLUSH: begin
          if (flushIdx == LAST_TAP) state_q <= IDLE;
        end
        IDLE: begin
          if (in_valid) begin
            newest_q <= wPtr;
            state_q  <= MAC;
          end
        end
        MAC: begin
          if (kIdx == LAST_TAP) begin
            drain_q <= '0;
            state_q <= (PIPE == 0) ? DUMP : DRAIN;
          end
        end
        DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_q <= DUMP;
          end else begin
            drain_q <= drain_q + 3'd1;
          end
        end
        DUMP: begin
          state_q <= OUT;
        end
        OUT: begin
          if (out_ready) state_q <= IDLE;
        end
        default: begin
          state_q <= FLUSH;
        end
      endcase
    end
  end

  // Output decode from the registered state. Everything is forced low while
  // RST is asserted so nothing downstream sees a stale strobe during reset.
  // The IDLE write is combinational on in_valid so the sample is stored in
  // the handshake cycle itself.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    wr_en     = 1'b0;
    wr_zero   = 1'b0;
    wr_addr   = '0;
    rd_addr   = '0;
    coef_addr = '0;
    mac_en    = 1'b0;
    out_sel   = 1'b0;
    if (!RST) begin
      case (state_q)
        FLUSH: begin
          wr_en   = 1'b1;
          wr_zero = 1'b1;
          wr_addr = flushIdx;
        end
        IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            wr_en   = 1'b1;
            wr_addr = wPtr;
          end
        end
        MAC: begin
          mac_en    = 1'b1;
          coef_addr = kIdx;
          rd_addr   = rdCalc;
        end
        DUMP: begin
          out_sel = 1'b1;
        end
        OUT: begin
          out_valid = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state_q != IDLE);

`ifdef FIR_SEQ_CNT_EN
  logic [15:0] out_count_q;

  // Completed-output counter; wraps naturally at 16 bits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_count_q <= '0;
    end else if (out_valid && out_ready) begin
      out_count_q <= out_count_q + 16'd1;
    end
  end

  assign out_count = out_count_q;
`endif

endmodule

// File: tb/tb_fir_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fir_sequencer
// Self-checking bench for fir_sequencer with N_TAPS=4, PIPE=1. A table of
// per-cycle records covers flush and the first two samples; hand-written
// sequences cover the held-output, held-input, reset-abort and (with
// FIR_SEQ_CNT_EN) output-counter cases.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fir_sequencer;

  logic       CLK;
  logic       RST;
  logic       inValid;
  logic       inReady;
  logic       outReady;
  logic       outValid;
  logic       wrEn;
  logic       wrZero;
  logic [1:0] wrAddr;
  logic [1:0] rdAddr;
  logic [1:0] coefAddr;
  logic       macEn;
  logic       outSel;
  logic       busy;
`ifdef FIR_SEQ_CNT_EN
  logic [15:0] outCount;
`endif

  int numChecks = 0;
  int numFails  = 0;

  fir_sequencer #(.N_TAPS(4), .AW(2), .PIPE(1)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .out_ready (outReady),
    .out_valid (outValid),
    .wr_en     (wrEn),
    .wr_zero   (wrZero),
    .wr_addr   (wrAddr),
    .rd_addr   (rdAddr),
    .coef_addr (coefAddr),
    .mac_en    (macEn),
    .out_sel   (outSel),
    .busy      (busy)
`ifdef FIR_SEQ_CNT_EN
    ,
    .out_count (outCount)
`endif
  );

  // 10 ns clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One cycle of stimulus plus the outputs expected during that cycle.
  typedef struct {
    logic       iv;
    logic       ordy;
    logic       inr;
    logic       wen;
    logic       wz;
    logic [1:0] wa;
    logic [1:0] ra;
    logic [1:0] ca;
    logic       men;
    logic       os;
    logic       ov;
    logic       bz;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic ordy, input logic inr,
                              input logic wen, input logic wz, input logic [1:0] wa,
                              input logic [1:0] ra, input logic [1:0] ca,
                              input logic men, input logic os, input logic ov,
                              input logic bz);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.inr = inr; v.wen = wen; v.wz = wz; v.wa = wa;
    v.ra = ra; v.ca = ca; v.men = men; v.os = os; v.ov = ov; v.bz = bz;
    return v;
  endfunction

  // Drive the inputs of one record.
  task automatic applyStimulus(input vec_t v);
    inValid  = v.iv;
    outReady = v.ordy;
  endtask

  // Compare the whole output bundle against the record.
  task automatic checkOutput(input vec_t v, input string tag);
    logic [12:0] act;
    logic [12:0] exp;
    act = {inReady, wrEn, wrZero, wrAddr, rdAddr, coefAddr, macEn, outSel, outValid, busy};
    exp = {v.inr, v.wen, v.wz, v.wa, v.ra, v.ca, v.men, v.os, v.ov, v.bz};
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got {inr,wen,wz,wa,ra,ca,men,os,ov,bz}=%b required %b",
               tag, act, exp);
    end
  endtask

  // Called at a falling edge: drive, settle, check, advance one cycle.
  task automatic stepVec(input vec_t v, input string tag);
    applyStimulus(v);
    #1;
    checkOutput(v, tag);
    @(negedge CLK);
  endtask

`ifdef FIR_SEQ_CNT_EN
  // Offer one sample and wait (bounded) for its result to be accepted.
  task automatic completeOne(input string tag);
    bit taken;
    bit done;
    taken    = 1'b0;
    done     = 1'b0;
    inValid  = 1'b1;
    outReady = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (!taken && inReady) taken = 1'b1;
      else if (taken && outValid) done = 1'b1;
      @(negedge CLK);
      if (taken) inValid = 1'b0;
    end
    if (!done) begin
      numChecks++;
      numFails++;
      $display("[TB] FAIL %s: timeout, got no output handshake within 40 cycles, required one", tag);
    end
  endtask

  task automatic checkCount(input logic [15:0] exp, input string tag);
    numChecks++;
    if (outCount !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got out_count=%0h required %0h", tag, outCount, exp);
    end
  endtask
`endif

  vec_t tbl[20];
  logic [1:0] rdS3[4];
  logic [1:0] rdS4[4];

  initial begin
    // Cycle 0 is the first cycle with RST low. First sample accepted in
    // cycle 4 (newest=0), second in cycle 12 (newest=1).
    tbl[0]  = mk(0,1, 0,1,1,2'd0, 2'd0,2'd0, 0,0,0,1);
    tbl[1]  = mk(0,1, 0,1,1,2'd1, 2'd0,2'd0, 0,0,0,1);
    tbl[2]  = mk(0,1, 0,1,1,2'd2, 2'd0,2'd0, 0,0,0,1);
    tbl[3]  = mk(0,1, 0,1,1,2'd3, 2'd0,2'd0, 0,0,0,1);
    tbl[4]  = mk(1,1, 1,1,0,2'd0, 2'd0,2'd0, 0,0,0,0);
    tbl[5]  = mk(0,1, 0,0,0,2'd0, 2'd0,2'd0, 1,0,0,1);
    tbl[6]  = mk(1,1, 0,0,0,2'd0, 2'd3,2'd1, 1,0,0,1);
    tbl[7]  = mk(0,1, 0,0,0,2'd0, 2'd2,2'd2, 1,0,0,1);
    tbl[8]  = mk(0,1, 0,0,0,2'd0, 2'd1,2'd3, 1,0,0,1);
    tbl[9]  = mk(0,1, 0,0,0,2'd0, 2'd0,2'd0, 0,0,0,1);
    tbl[10] = mk(1,1, 0,0,0,2'd0, 2'd0,2'd0, 0,1,0,1);
    tbl[11] = mk(0,1, 0,0,0,2'd0, 2'd0,2'd0, 0,0,1,1);
    tbl[12] = mk(1,1, 1,1,0,2'd1, 2'd0,2'd0, 0,0,0,0);
    tbl[13] = mk(0,1, 0,0,0,2'd0, 2'd1,2'd0, 1,0,0,1);
    tbl[14] = mk(0,1, 0,0,0,2'd0, 2'd0,2'd1, 1,0,0,1);
    tbl[15] = mk(0,1, 0,0,0,2'd0, 2'd3,2'd2, 1,0,0,1);
    tbl[16] = mk(0,1, 0,0,0,2'd0, 2'd2,2'd3, 1,0,0,1);
    tbl[17] = mk(0,1, 0,0,0,2'd0, 2'd0,2'd0, 0,0,0,1);
    tbl[18] = mk(0,1, 0,0,0,2'd0, 2'd0,2'd0, 0,1,0,1);
    tbl[19] = mk(0,1, 0,0,0,2'd0, 2'd0,2'd0, 0,0,1,1);
    rdS3 = '{2'd2, 2'd1, 2'd0, 2'd3};
    rdS4 = '{2'd3, 2'd2, 2'd1, 2'd0};

    // Reset phase: outputs quiet even with in_valid high.
    RST      = 1'b1;
    inValid  = 1'b1;
    outReady = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    checkOutput(mk(1,1, 0,0,0,2'd0, 2'd0,2'd0, 0,0,0,1), "reset_quiet");
    @(negedge CLK);
    RST     = 1'b0;
    inValid = 1'b0;

    // Flush and the first two samples.
    for (int i = 0; i < 20; i++) begin
      stepVec(tbl[i], $sformatf("table[%0d]", i));
    end

    // Third sample at wr_addr 2, with a fourth held on in_valid while busy
    // and the result held in OUT for 10 cycles.
    stepVec(mk(1,0, 1,1,0,2'd2, 2'd0,2'd0, 0,0,0,0), "idle_s3");
    for (int i = 0; i < 4; i++) begin
      stepVec(mk(1,0, 0,0,0,2'd0, rdS3[i],2'(i), 1,0,0,1), $sformatf("mac_s3[%0d]", i));
    end
    stepVec(mk(1,0, 0,0,0,2'd0, 2'd0,2'd0, 0,0,0,1), "drain_s3");
    stepVec(mk(1,0, 0,0,0,2'd0, 2'd0,2'd0, 0,1,0,1), "dump_s3");
    for (int i = 0; i < 10; i++) begin
      stepVec(mk(1,0, 0,0,0,2'd0, 2'd0,2'd0, 0,0,1,1), $sformatf("hold_out[%0d]", i));
    end
    stepVec(mk(1,1, 0,0,0,2'd0, 2'd0,2'd0, 0,0,1,1), "out_release");

    // The held sample is taken the cycle after release, at wr_addr 3.
    stepVec(mk(1,1, 1,1,0,2'd3, 2'd0,2'd0, 0,0,0,0), "idle_s4");
    for (int i = 0; i < 4; i++) begin
      stepVec(mk(1,1, 0,0,0,2'd0, rdS4[i],2'(i), 1,0,0,1), $sformatf("mac_s4[%0d]", i));
    end
    stepVec(mk(1,1, 0,0,0,2'd0, 2'd0,2'd0, 0,0,0,1), "drain_s4");
    stepVec(mk(1,1, 0,0,0,2'd0, 2'd0,2'd0, 0,1,0,1), "dump_s4");
    stepVec(mk(1,1, 0,0,0,2'd0, 2'd0,2'd0, 0,0,1,1), "out_s4");

    // Fifth sample wraps to wr_addr 0 and reads 0,3,2,1.
    stepVec(mk(1,1, 1,1,0,2'd0, 2'd0,2'd0, 0,0,0,0), "idle_s5");
    stepVec(mk(0,1, 0,0,0,2'd0, 2'd0,2'd0, 1,0,0,1), "mac_s5[0]");
    stepVec(mk(0,1, 0,0,0,2'd0, 2'd3,2'd1, 1,0,0,1), "mac_s5[1]");

    // Reset pulse in the third MAC cycle aborts; flush repeats with no output.
    RST = 1'b1;
    stepVec(mk(0,1, 0,0,0,2'd0, 2'd0,2'd0, 0,0,0,1), "rst_in_mac");
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stepVec(mk(0,1, 0,1,1,2'(i), 2'd0,2'd0, 0,0,0,1), $sformatf("reflush[%0d]", i));
    end
    stepVec(mk(1,1, 1,1,0,2'd0, 2'd0,2'd0, 0,0,0,0), "idle_after_rst");
    stepVec(mk(0,1, 0,0,0,2'd0, 2'd0,2'd0, 1,0,0,1), "mac_after_rst");

`ifdef FIR_SEQ_CNT_EN
    // Output counter: cleared by reset, counts handshakes, wraps at 16 bits.
    RST = 1'b1;
    inValid = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    checkCount(16'h0000, "count_reset");
    @(negedge CLK);
    RST = 1'b0;
    completeOne("count_txn1");
    completeOne("count_txn2");
    completeOne("count_txn3");
    #1;
    checkCount(16'h0003, "count_three");
    @(negedge CLK);
    force dut.out_count_q = 16'hFFFF;
    @(negedge CLK);
    release dut.out_count_q;
    completeOne("count_txn_wrap");
    #1;
    checkCount(16'h0000, "count_wrap");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
